// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode constants, immediate and buffer-state enums,
// the buffered entry payload, and opcode classification helpers.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_JAL      = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM   = 7'h73;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_TWO
    } buf_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: return IMM_I;
            OPC_STORE:                      return IMM_S;
            OPC_BRANCH:                     return IMM_B;
            OPC_LUI, OPC_AUIPC:             return IMM_U;
            OPC_JAL:                        return IMM_J;
            default:                        return IMM_NONE;
        endcase
    endfunction

    function automatic logic is_supported_opcode(input logic [6:0] opcode);
        case (opcode)
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: sign-extended immediate selected by opcode format.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] i_instr,
    output logic [XLEN-1:0] o_imm
);

    imm_type_e w_type;

    assign w_type = imm_type_of(i_instr[6:0]);

    always_comb begin
        o_imm = '0;
        case (w_type)
            IMM_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U: o_imm = {i_instr[31:12], 12'b0};
            IMM_J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                            i_instr[20], i_instr[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/instruction_decode_unit.sv
// Two-entry skid buffer between fetch and execute that decodes the head RV32I word.
// Optional illegal-encoding detection is enabled by defining DECODE_ILLEGAL_CHECK_EN.
module instruction_decode_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instruction,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    output logic [6:0]  id_opcode,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7,
    output logic [31:0] id_imm,
    output logic        id_illegal
);

    localparam entry_t EMPTY_ENTRY = '{pc: 32'h0, instr: NOP_INSTR};

    buf_state_e r_state;
    entry_t     r_head;
    entry_t     r_second;
    logic       r_if_ready;
    logic       r_id_valid;

    logic       w_push;
    logic       w_pop;
    entry_t     w_in;

    assign w_push = if_valid && r_if_ready;
    assign w_pop  = r_id_valid && id_ready;
    assign w_in   = '{pc: if_pc, instr: if_instruction};

    // Head always holds the oldest word; the second slot only refills the head on a pop.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_state    <= BUF_EMPTY;
            r_head     <= EMPTY_ENTRY;
            r_second   <= EMPTY_ENTRY;
            r_if_ready <= 1'b1;
            r_id_valid <= 1'b0;
        end else begin
            case (r_state)
                BUF_EMPTY: begin
                    if (w_push) begin
                        r_head     <= w_in;
                        r_state    <= BUF_ONE;
                        r_id_valid <= 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (w_push && w_pop) begin
                        r_head <= w_in;
                    end else if (w_push) begin
                        r_second   <= w_in;
                        r_state    <= BUF_TWO;
                        r_if_ready <= 1'b0;
                    end else if (w_pop) begin
                        r_head     <= EMPTY_ENTRY;
                        r_state    <= BUF_EMPTY;
                        r_id_valid <= 1'b0;
                    end
                end
                BUF_TWO: begin
                    if (w_pop) begin
                        r_head     <= r_second;
                        r_state    <= BUF_ONE;
                        r_if_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= BUF_EMPTY;
                    r_head     <= EMPTY_ENTRY;
                    r_if_ready <= 1'b1;
                    r_id_valid <= 1'b0;
                end
            endcase
        end
    end

    assign if_ready       = r_if_ready;
    assign id_valid       = r_id_valid;
    assign id_pc          = r_head.pc;
    assign id_instruction = r_head.instr;
    assign id_opcode      = r_head.instr[6:0];
    assign id_rd          = r_head.instr[11:7];
    assign id_funct3      = r_head.instr[14:12];
    assign id_rs1         = r_head.instr[19:15];
    assign id_rs2         = r_head.instr[24:20];
    assign id_funct7      = r_head.instr[31:25];

    imm_gen u_imm_gen (
        .i_instr (r_head.instr),
        .o_imm   (id_imm)
    );

`ifdef DECODE_ILLEGAL_CHECK_EN
    assign id_illegal = r_id_valid &&
                        ((r_head.instr[1:0] != 2'b11) || !is_supported_opcode(r_head.instr[6:0]));
`else
    assign id_illegal = 1'b0;
`endif

endmodule

// File: doc/instruction_decode_unit.md
INSTRUCTION_DECODE_UNIT -- requirements
Module: instruction_decode_unit

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h00000013; instruction word presented on id_instruction while empty.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  discard all buffered entries.
REQ-005 SHALL have port if_valid  input  1  fetch offers a word.
REQ-006 SHALL have port if_ready  output  1  decode can accept a word.
REQ-007 SHALL have port if_pc  input  32  PC of offered word.
REQ-008 SHALL have port if_instruction  input  32  offered instruction word.
REQ-009 SHALL have port id_valid  output  1  decoded head entry valid.
REQ-010 SHALL have port id_ready  input  1  execute consumes head entry.
REQ-011 SHALL have ports id_pc / id_instruction  output  32 each  head PC and raw word.
REQ-012 SHALL have ports id_opcode 7, id_rd 5, id_rs1 5, id_rs2 5, id_funct3 3, id_funct7 7  output  decoded fields of head.
REQ-013 SHALL have port id_imm  output  32  sign-extended immediate of head.
REQ-014 SHALL have port id_illegal  output  1  head is not a supported RV32I encoding.

Function
REQ-015 SHALL implement a 2-entry skid buffer with states EMPTY, ONE, TWO.
REQ-016 SHALL accept a word on an edge where if_valid && if_ready; SHALL retire head on an edge where id_valid && id_ready.
REQ-017 SHALL drive if_ready = 1 in EMPTY and ONE, 0 in TWO; id_valid = 1 in ONE and TWO.
REQ-018 SHALL transition: EMPTY+push->ONE; ONE+push only->TWO; ONE+pop only->EMPTY; ONE+push+pop->ONE (new word becomes head); TWO+pop->ONE (second entry becomes head); all else hold.
REQ-019 SHALL present an accepted word on id_* in the cycle after the accepting edge (1-cycle latency); decode fields combinational from head entry.
REQ-020 SHALL preserve order: second entry never overtakes head.
REQ-021 SHALL, on flush at an edge, go to EMPTY and drop any word offered in that cycle; flush beats push and pop.
REQ-022 SHALL, when EMPTY, drive id_pc = 0, id_instruction = NOP_INSTR and its decode, id_illegal = 0.
REQ-023 SHALL produce id_imm by opcode: I-type (0x03,0x13,0x67) {20{i[31]},i[31:20]}; S (0x23) {20{i[31]},i[31:25],i[11:7]}; B (0x63) {19{i[31]},i[31],i[7],i[30:25],i[11:8],0}; U (0x37,0x17) {i[31:12],12'b0}; J (0x6F) {11{i[31]},i[31],i[19:12],i[20],i[30:21],0}; otherwise 0.
REQ-024 SHALL hold all id_* outputs stable while id_valid && !id_ready.

Reset
REQ-025 SHALL, on an edge with reset == 0, enter EMPTY; if_ready = 1, id_valid = 0, outputs per REQ-022.
REQ-026 SHALL, on reset mid-operation, discard all buffered entries without retiring any.

Configuration
REQ-027 SHALL honour macro DECODE_ILLEGAL_CHECK_EN: defined -> id_illegal = 1 when i[1:0] != 2'b11 or opcode not in {0x03,0x0F,0x13,0x17,0x23,0x33,0x37,0x63,0x67,0x6F,0x73}; undefined -> id_illegal tied 0 with no check logic.

Structure
REQ-028 SHALL place opcode constants, immediate-type enum and buffer state enum in shared package riscv_pkg.
REQ-029 SHALL put immediate generation in sub-module imm_gen (combinational, instruction in, imm out).

Verification
REQ-030 SHALL cover: push pc 0x0, 0x00500093 with id_ready=1 -> next cycle id_valid=1, rd=1, rs1=0, funct3=0, imm=0x00000005, illegal=0.
REQ-031 SHALL cover: id_ready=0, push 0x11111111 then 0x22222222 -> if_ready=0 after second; third offer not accepted; release id_ready -> heads 0x11111111 then 0x22222222 in order.
REQ-032 SHALL cover: with DECODE_ILLEGAL_CHECK_EN, head 0x11111111 -> id_illegal=1; without macro -> id_illegal=0.
REQ-033 SHALL cover: in TWO, assert flush while if_valid=1 -> next cycle id_valid=0, if_ready=1, id_instruction=0x00000013.
REQ-034 SHALL cover: head 0xFE000EE3 (beq x0,x0,-4) -> opcode 0x63, imm=0xFFFFFFFC; head 0x123450B7 (lui) -> imm=0x12345000.
REQ-035 SHALL cover: reset=0 held one edge while in ONE -> EMPTY, id_valid=0, if_ready=1.
